regfile_ckpt: RTL and testbench
===============================

# regfile_ckpt

Parametrised multi-port architectural register file with single-cycle checkpoint save/restore for branch-misprediction recovery in the OoO core. Extends the plain register file with a configurable number of shadow checkpoint slots, per-slot valid tracking, a defined write-port priority and an error pulse for illegal checkpoint requests. It sits between commit/writeback and the rename-stage operand read.

## Interface

Parameters:
- REG_NUM, 32, number of registers.
- DATA_WIDTH, 32, bits per register.
- WRITE_PORTS, 2, number of write ports.
- READ_PORTS, 4, number of read ports.
- ZERO_KEEP, 1, registers [0 : ZERO_KEEP-1] are hardwired to 0.
- CKPT_NUM, 4, number of checkpoint slots, at least 1.

Ports (AW = $clog2(REG_NUM), CW = max(1, $clog2(CKPT_NUM))):
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- we  in  WRITE_PORTS  per-port write enable.
- waddr  in  WRITE_PORTS×AW  write addresses.
- wdata  in  WRITE_PORTS×DATA_WIDTH  write data.
- raddr  in  READ_PORTS×AW  read addresses.
- rdata  out  READ_PORTS×DATA_WIDTH  read data, combinational.
- ckpt_save  in  1  copy the register state into slot ckpt_save_id.
- ckpt_save_id  in  CW  target slot of a save.
- ckpt_restore  in  1  replace the register state with slot ckpt_restore_id.
- ckpt_restore_id  in  CW  source slot of a restore.
- ckpt_release  in  1  invalidate slot ckpt_release_id.
- ckpt_release_id  in  CW  slot to release.
- ckpt_valid  out  CKPT_NUM  per-slot valid flags, registered.
- ckpt_err  out  1  one-cycle pulse for an illegal checkpoint request, registered.

## Operation

- Next state regs_new = regs with writes applied. A write is applied only when we[j] is set and waddr[j] ≥ ZERO_KEEP. If several ports hit the same address, the highest port index wins.
- Save, when no restore is active: slot[ckpt_save_id] <= regs_new, so a checkpoint includes writes made in the same cycle. The slot's valid flag is set. Saving over a valid slot overwrites it silently.
- Restore of a valid slot: regs <= slot[ckpt_restore_id]. All writes in that cycle are discarded. The slot's valid flag is cleared (the slot is consumed).
- Restore of an invalid slot: the restore is ignored, writes proceed normally, and ckpt_err pulses.
- Save and restore in the same cycle: the restore takes effect, the save is dropped, and ckpt_err pulses.
- Release clears ckpt_valid[ckpt_release_id]. If the same slot is also saved that cycle, the save wins and the flag stays set. Releasing an invalid slot is a no-op with no error.
- A save_id, restore_id or release_id ≥ CKPT_NUM is illegal: the request is ignored and ckpt_err pulses.
- Indices below ZERO_KEEP always read 0, both live and inside checkpoints.

## Timing

- Reset: all registers 0, ckpt_valid = 0, ckpt_err = 0. Slot contents are don't-care after reset because they are guarded by valid.
- rdata is combinational from regs; there is no bypass unless the configuration macro below is defined.
- Writes, saves, restores and releases are visible at the clock edge following the request cycle.
- ckpt_err is asserted during the cycle after the offending request and lasts exactly one cycle.
- If rst is asserted mid-operation it overrides every other request in that cycle. Pending checkpoints are lost.

## Configuration

- REGFILE_CKPT_WRITE_FIRST_EN:
  - Defined: rdata[i] reads regs_new, so a same-cycle write is forwarded to readers. In a restore cycle, reads return the restored slot contents.
  - Undefined: rdata[i] reads regs only.

## Test plan

- Reset, then write r5 = 0xDEADBEEF on port 0 -> next cycle raddr = 5 returns 0xDEADBEEF. Writing r0 = 0x1 -> r0 still reads 0.
- Ports 0 and 1 both write r7, with 0x11 and 0x22 -> r7 reads 0x22.
- r3 = 0xA, save slot 2 while writing r3 = 0xB in the same cycle, then write r3 = 0xC, then restore slot 2 -> r3 reads 0xB, ckpt_valid[2] goes from 1 to 0, ckpt_err stays 0.
- Restore slot 1 while it is invalid -> ckpt_err = 1 for one cycle and state unchanged. Save and restore in the same cycle -> restore applied, ckpt_err = 1, save slot not set.
- Restore slot 0 together with a write r9 = 0x55 -> r9 holds its checkpoint value, not 0x55.
- With REGFILE_CKPT_WRITE_FIRST_EN defined, write r4 = 0x77 and read r4 in the same cycle -> rdata = 0x77. Without the macro -> rdata is the old value.

Source files
------------

// File: rtl/regfile_ckpt.sv
// Multi-port register file with shadow checkpoint slots for misprediction recovery.
// Optional macro REGFILE_CKPT_WRITE_FIRST_EN forwards same-cycle next state to the read ports.
module regfile_ckpt #(
    parameter int unsigned REG_NUM     = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WRITE_PORTS = 2,
    parameter int unsigned READ_PORTS  = 4,
    parameter int unsigned ZERO_KEEP   = 1,
    parameter int unsigned CKPT_NUM    = 4,
    localparam int unsigned AW = $clog2(REG_NUM),
    localparam int unsigned CW = (CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [WRITE_PORTS-1:0]                we,
    input  logic [WRITE_PORTS-1:0][AW-1:0]        waddr,
    input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata,
    input  logic [READ_PORTS-1:0][AW-1:0]         raddr,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rdata,
    input  logic                                  ckpt_save,
    input  logic [CW-1:0]                         ckpt_save_id,
    input  logic                                  ckpt_restore,
    input  logic [CW-1:0]                         ckpt_restore_id,
    input  logic                                  ckpt_release,
    input  logic [CW-1:0]                         ckpt_release_id,
    output logic [CKPT_NUM-1:0]                   ckpt_valid,
    output logic                                  ckpt_err
);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t                regs_q   [REG_NUM];
    word_t                regs_d   [REG_NUM];
    word_t                regs_new [REG_NUM];
    word_t                rd_src   [REG_NUM];
    word_t                slots_q  [CKPT_NUM][REG_NUM];
    logic [CKPT_NUM-1:0]  valid_q, valid_d;
    logic                 err_q, err_d;

    logic save_id_ok, restore_id_ok, release_id_ok;
    logic restore_hit, save_do;

    // Architectural writes; ascending loop lets the highest port index win collisions
    always_comb begin
        regs_new = regs_q;
        for (int j = 0; j < int'(WRITE_PORTS); j++) begin
            if (we[j] && (32'(waddr[j]) >= ZERO_KEEP) && (32'(waddr[j]) < REG_NUM)) begin
                regs_new[waddr[j]] = wdata[j];
            end
        end
    end

    always_comb begin
        save_id_ok    = 32'(ckpt_save_id)    < CKPT_NUM;
        restore_id_ok = 32'(ckpt_restore_id) < CKPT_NUM;
        release_id_ok = 32'(ckpt_release_id) < CKPT_NUM;

        restore_hit = ckpt_restore && restore_id_ok && valid_q[ckpt_restore_id];
        save_do     = ckpt_save && save_id_ok && !restore_hit;

        err_d = (ckpt_save    && !save_id_ok)
              || (ckpt_restore && !restore_id_ok)
              || (ckpt_release && !release_id_ok)
              || (ckpt_restore && restore_id_ok && !valid_q[ckpt_restore_id])
              || (ckpt_save    && restore_hit);

        // Release first so a same-slot save keeps the flag set
        valid_d = valid_q;
        if (ckpt_release && release_id_ok) begin
            valid_d[ckpt_release_id] = 1'b0;
        end
        if (restore_hit) begin
            valid_d[ckpt_restore_id] = 1'b0;
        end
        if (save_do) begin
            valid_d[ckpt_save_id] = 1'b1;
        end
    end

    // A successful restore discards every write of the cycle
    always_comb begin
        for (int r = 0; r < int'(REG_NUM); r++) begin
            regs_d[r] = restore_hit ? slots_q[ckpt_restore_id][r] : regs_new[r];
        end
    end

    always_comb begin
`ifdef REGFILE_CKPT_WRITE_FIRST_EN
        rd_src = regs_d;
`else
        rd_src = regs_q;
`endif
        for (int i = 0; i < int'(READ_PORTS); i++) begin
            rdata[i] = '0;
            if ((32'(raddr[i]) >= ZERO_KEEP) && (32'(raddr[i]) < REG_NUM)) begin
                rdata[i] = rd_src[raddr[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(REG_NUM); r++) begin
                regs_q[r] <= '0;
            end
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Slot payload needs no reset: it is only ever consumed while its valid flag is set
    always_ff @(posedge clk) begin
        if (!rst && save_do) begin
            slots_q[ckpt_save_id] <= regs_new;
        end
    end

    assign ckpt_valid = valid_q;
    assign ckpt_err   = err_q;

endmodule

// File: tb/tb_regfile_ckpt.sv
// Scoreboard bench for regfile_ckpt: driver pushes model predictions, monitor compares each cycle.
module tb_regfile_ckpt;

    localparam int RN = 32;
    localparam int DW = 32;
    localparam int WP = 2;
    localparam int RP = 4;
    localparam int ZK = 1;
    localparam int CN = 4;
    localparam int AW = 5;
    localparam int CW = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [WP-1:0]          we;
    logic [WP-1:0][AW-1:0]  waddr;
    logic [WP-1:0][DW-1:0]  wdata;
    logic [RP-1:0][AW-1:0]  raddr;
    logic [RP-1:0][DW-1:0]  rdata;
    logic                   ckpt_save, ckpt_restore, ckpt_release;
    logic [CW-1:0]          ckpt_save_id, ckpt_restore_id, ckpt_release_id;
    logic [CN-1:0]          ckpt_valid;
    logic                   ckpt_err;

    regfile_ckpt dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata),
        .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
        .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
        .ckpt_release(ckpt_release), .ckpt_release_id(ckpt_release_id),
        .ckpt_valid(ckpt_valid), .ckpt_err(ckpt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                    rst;
        logic [WP-1:0]         we;
        logic [WP-1:0][AW-1:0] waddr;
        logic [WP-1:0][DW-1:0] wdata;
        logic [RP-1:0][AW-1:0] raddr;
        bit                    save;
        logic [CW-1:0]         sid;
        bit                    restore;
        logic [CW-1:0]         rid;
        bit                    rel;
        logic [CW-1:0]         relid;
    } op_t;

    typedef struct {
        logic [RP-1:0][DW-1:0] rdata;
        logic [CN-1:0]         valid;
        logic                  err;
        int                    cyc;
    } exp_t;

    exp_t sb[$];

    // Reference state: architectural regs, checkpoint copies, per-slot valid, pending error
    logic [DW-1:0] m_regs  [RN];
    logic [DW-1:0] m_slots [CN][RN];
    logic [CN-1:0] m_valid;
    logic          m_err;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  drv_done = 0;

    function automatic op_t idle();
        op_t o;
        o.rst = 0; o.we = '0; o.waddr = '0; o.wdata = '0;
        o.raddr = {5'd9, 5'd7, 5'd3, 5'd0};
        o.save = 0; o.sid = '0; o.restore = 0; o.rid = '0; o.rel = 0; o.relid = '0;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.rst = ($urandom_range(0, 99) == 0);
        o.we  = WP'($urandom);
        for (int j = 0; j < WP; j++) begin
            o.waddr[j] = AW'($urandom_range(0, ($urandom_range(0, 3) == 0) ? RN - 1 : 11));
            o.wdata[j] = $urandom;
        end
        for (int i = 0; i < RP; i++) o.raddr[i] = AW'($urandom_range(0, 11));
        o.save    = ($urandom_range(0, 3) == 0); o.sid   = CW'($urandom);
        o.restore = ($urandom_range(0, 5) == 0); o.rid   = CW'($urandom);
        o.rel     = ($urandom_range(0, 5) == 0); o.relid = CW'($urandom);
        return o;
    endfunction

    task automatic issue(input op_t o);
        logic [DW-1:0] nxt [RN];
        exp_t e;
        bit   hit;
        int   a;
        @(posedge clk);
        #1;
        rst = o.rst; we = o.we; waddr = o.waddr; wdata = o.wdata; raddr = o.raddr;
        ckpt_save = o.save; ckpt_save_id = o.sid;
        ckpt_restore = o.restore; ckpt_restore_id = o.rid;
        ckpt_release = o.rel; ckpt_release_id = o.relid;

        nxt = m_regs;
        for (int j = 0; j < WP; j++) begin
            a = int'(o.waddr[j]);
            if (o.we[j] && a >= ZK) nxt[a] = o.wdata[j];
        end
        hit = o.restore && (int'(o.rid) < CN) && m_valid[o.rid];

        for (int i = 0; i < RP; i++) begin
            a = int'(o.raddr[i]);
`ifdef REGFILE_CKPT_WRITE_FIRST_EN
            e.rdata[i] = hit ? m_slots[o.rid][a] : nxt[a];
`else
            e.rdata[i] = m_regs[a];
`endif
            if (a < ZK) e.rdata[i] = '0;
        end
        e.valid = m_valid;
        e.err   = m_err;
        e.cyc   = cyc;
        sb.push_back(e);
        cyc++;

        if (o.rst) begin
            for (int r = 0; r < RN; r++) m_regs[r] = '0;
            m_valid = '0;
            m_err   = 1'b0;
        end else begin
            m_err = (o.save && int'(o.sid) >= CN) || (o.restore && int'(o.rid) >= CN)
                 || (o.rel && int'(o.relid) >= CN)
                 || (o.restore && int'(o.rid) < CN && !m_valid[o.rid])
                 || (o.save && hit);
            if (o.rel && int'(o.relid) < CN) m_valid[o.relid] = 1'b0;
            if (hit) begin
                m_regs = m_slots[o.rid];
                m_valid[o.rid] = 1'b0;
            end else begin
                m_regs = nxt;
            end
            if (o.save && int'(o.sid) < CN && !hit) begin
                m_slots[o.sid] = nxt;
                m_valid[o.sid] = 1'b1;
            end
        end
    endtask

    // Driver: directed recovery scenarios followed by randomized traffic
    initial begin
        op_t o;
        for (int r = 0; r < RN; r++) m_regs[r] = '0;
        m_valid = '0;
        m_err   = 1'b0;
        o = idle();
        rst = 1'b1; we = o.we; waddr = o.waddr; wdata = o.wdata; raddr = o.raddr;
        ckpt_save = 0; ckpt_save_id = '0; ckpt_restore = 0; ckpt_restore_id = '0;
        ckpt_release = 0; ckpt_release_id = '0;
        repeat (2) @(posedge clk);

        o = idle(); o.we = 2'b01; o.waddr[0] = 5'd5; o.wdata[0] = 32'hDEADBEEF; issue(o);
        o = idle(); o.raddr[1] = 5'd5; o.we = 2'b01; o.waddr[0] = 5'd0; o.wdata[0] = 32'h1; issue(o);
        o = idle(); o.raddr[1] = 5'd5; o.we = 2'b11; o.waddr[0] = 5'd7; o.waddr[1] = 5'd7;
        o.wdata[0] = 32'h11; o.wdata[1] = 32'h22; issue(o);
        o = idle(); o.we = 2'b01; o.waddr[0] = 5'd3; o.wdata[0] = 32'hA; issue(o);
        o = idle(); o.save = 1; o.sid = 2'd2; o.we = 2'b01; o.waddr[0] = 5'd3; o.wdata[0] = 32'hB; issue(o);
        o = idle(); o.we = 2'b01; o.waddr[0] = 5'd3; o.wdata[0] = 32'hC; issue(o);
        o = idle(); o.restore = 1; o.rid = 2'd2; issue(o);
        o = idle(); issue(o);
        o = idle(); o.restore = 1; o.rid = 2'd1; issue(o);
        o = idle(); o.we = 2'b10; o.waddr[1] = 5'd9; o.wdata[1] = 32'h99; o.save = 1; o.sid = 2'd0; issue(o);
        o = idle(); issue(o);
        o = idle(); o.save = 1; o.sid = 2'd3; o.restore = 1; o.rid = 2'd0; issue(o);
        o = idle(); o.we = 2'b01; o.waddr[0] = 5'd9; o.wdata[0] = 32'h1234; o.save = 1; o.sid = 2'd0; issue(o);
        o = idle(); o.restore = 1; o.rid = 2'd0; o.we = 2'b01; o.waddr[0] = 5'd9; o.wdata[0] = 32'h55; issue(o);
        o = idle(); o.save = 1; o.sid = 2'd1; o.rel = 1; o.relid = 2'd1; issue(o);
        o = idle(); o.rel = 1; o.relid = 2'd1; issue(o);
        o = idle(); o.raddr[1] = 5'd4; o.we = 2'b01; o.waddr[0] = 5'd4; o.wdata[0] = 32'h77; issue(o);
        o = idle(); o.raddr[1] = 5'd4; issue(o);

        for (int n = 0; n < 600; n++) issue(rand_op());
        o = idle(); issue(o);
        drv_done = 1;
    end

    // Monitor: every cycle the DUT presents rdata/ckpt_valid/ckpt_err
    initial begin
        exp_t e;
        while (!(drv_done && sb.size() == 0)) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < RP; i++) begin
                    checks++;
                    if (rdata[i] !== e.rdata[i]) begin
                        failures++;
                        $display("FAIL rdata[%0d] cyc=%0d raddr=%0d got=%h exp=%h",
                                 i, e.cyc, raddr[i], rdata[i], e.rdata[i]);
                    end
                end
                checks++;
                if (ckpt_valid !== e.valid) begin
                    failures++;
                    $display("FAIL ckpt_valid cyc=%0d got=%b exp=%b", e.cyc, ckpt_valid, e.valid);
                end
                checks++;
                if (ckpt_err !== e.err) begin
                    failures++;
                    $display("FAIL ckpt_err cyc=%0d got=%b exp=%b", e.cyc, ckpt_err, e.err);
                end
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
